pm1_share_arb: RTL and testbench

- Sequential front-end that shares one combinational pm1 decode datapath among NREQ requesters.
- Round-robin arbitration picks one request, drives its 16-bit input vector into pm1, and waits SETTLE cycles for the datapath to settle.
- It then captures the 13-bit result and returns it on a single response channel tagged with the requester id.
- Only one transaction is in flight at a time; the block sits between pm1 and the client blocks that need decodes.

---
 rtl/pm1_share_pkg.sv | 52 +++++
 rtl/pm1_rr_pick.sv | 35 +++
 rtl/pm1_share_arb.sv | 132 +++++++++++++
 tb/tb_pm1_share_arb.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pm1_share_pkg.sv
// Shared types and constants for the pm1 sharing front-end.
package pm1_share_pkg;

    localparam int unsigned IW  = 16;
    localparam int unsigned OW  = 13;
    localparam int unsigned CW  = 4;
    localparam int unsigned PCW = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE_S = 2'd1,
        RESP     = 2'd2
    } state_e;

    // pm1 input bit positions
    localparam int unsigned PM_A = 15;
    localparam int unsigned PM_B = 14;
    localparam int unsigned PM_C = 13;
    localparam int unsigned PM_D = 12;
    localparam int unsigned PM_E = 11;
    localparam int unsigned PM_G = 10;
    localparam int unsigned PM_H = 9;
    localparam int unsigned PM_I = 8;
    localparam int unsigned PM_J = 7;
    localparam int unsigned PM_K = 6;
    localparam int unsigned PM_L = 5;
    localparam int unsigned PM_M = 4;
    localparam int unsigned PM_N = 3;
    localparam int unsigned PM_O = 2;
    localparam int unsigned PM_P = 1;
    localparam int unsigned PM_Q = 0;

    // pm1 output bit positions
    localparam int unsigned PM_R  = 12;
    localparam int unsigned PM_S  = 11;
    localparam int unsigned PM_T  = 10;
    localparam int unsigned PM_U  = 9;
    localparam int unsigned PM_V  = 8;
    localparam int unsigned PM_W  = 7;
    localparam int unsigned PM_X  = 6;
    localparam int unsigned PM_Y  = 5;
    localparam int unsigned PM_Z  = 4;
    localparam int unsigned PM_A0 = 3;
    localparam int unsigned PM_B0 = 2;
    localparam int unsigned PM_C0 = 1;
    localparam int unsigned PM_D0 = 0;

    function automatic logic [PCW-1:0] sat_inc(input logic [PCW-1:0] v);
        return (v == {PCW{1'b1}}) ? v : v + PCW'(1);
    endfunction

endpackage

// File: rtl/pm1_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to 0.
module pm1_rr_pick #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] id,
    output logic                    any
);

    localparam int unsigned IDW = $clog2(NREQ);

    // Upper pass covers ptr..NREQ-1, lower pass handles the wrap.
    always_comb begin
        gnt = '0;
        id  = '0;
        any = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!any && req[i] && (i >= int'(ptr))) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                id     = IDW'(i);
            end
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!any && req[i]) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                id     = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/pm1_share_arb.sv
// Shares one external pm1 decode datapath among NREQ requesters, one transaction at a time.
// Optional per-requester grant counters on perf_cnt when PM1_SHARE_ARB_PERF_EN is defined.
module pm1_share_arb
    import pm1_share_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*IW-1:0]      req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [OW-1:0]           rsp_data,
    output logic [IW-1:0]           pm_in,
    input  logic [OW-1:0]           pm_out,
`ifdef PM1_SHARE_ARB_PERF_EN
    output logic [NREQ*PCW-1:0]     perf_cnt,
`endif
    output logic                    busy
);

    localparam int unsigned IDW = $clog2(NREQ);

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]  pm_in_d;
    logic [IDW-1:0] rsp_id_d;
    logic [OW-1:0]  rsp_data_d;
    logic           rsp_valid_d;
    logic           busy_d;

    logic [NREQ-1:0] pick_gnt;
    logic [IDW-1:0]  pick_id;
    logic            pick_any;
    logic            grant_fire;

    pm1_rr_pick #(.NREQ(NREQ)) u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .id  (pick_id),
        .any (pick_any)
    );

    assign grant_fire = (state_q == IDLE) && pick_any;

    // Next-state and datapath selection; req_ready is the only combinational output.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        pm_in_d    = pm_in;
        rsp_id_d   = rsp_id;
        rsp_data_d = rsp_data;
        req_ready  = '0;
        unique case (state_q)
            IDLE: begin
                if (grant_fire) begin
                    req_ready = pick_gnt & {NREQ{rst_n}};
                    for (int i = 0; i < int'(NREQ); i++) begin
                        if (pick_gnt[i]) pm_in_d = req_data[i*IW +: IW];
                    end
                    rsp_id_d = pick_id;
                    ptr_d    = (pick_id == IDW'(NREQ - 1)) ? '0 : pick_id + IDW'(1);
                    cnt_d    = CW'(SETTLE - 1);
                    state_d  = SETTLE_S;
                end
            end
            SETTLE_S: begin
                if (cnt_q == '0) begin
                    rsp_data_d = pm_out;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            pm_in     <= '0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            pm_in     <= pm_in_d;
            rsp_id    <= rsp_id_d;
            rsp_data  <= rsp_data_d;
            rsp_valid <= rsp_valid_d;
            busy      <= busy_d;
        end
    end

`ifdef PM1_SHARE_ARB_PERF_EN
    logic [PCW-1:0] perf_q [NREQ];

    // Saturating per-requester grant counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREQ); i++) perf_q[i] <= '0;
        end else if (grant_fire) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (pick_gnt[i]) perf_q[i] <= sat_inc(perf_q[i]);
            end
        end
    end

    for (genvar g = 0; g < int'(NREQ); g++) begin : g_perf
        assign perf_cnt[g*PCW +: PCW] = perf_q[g];
    end
`endif

endmodule

// File: tb/tb_pm1_share_arb.sv
// Directed bench for pm1_share_arb: SETTLE=1 instance with a pm1 stand-in, plus a SETTLE=3 instance.
module tb_pm1_share_arb;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // SETTLE=1 instance
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [12:0] rsp_data;
    logic [15:0] pm_in;
    logic [12:0] pm_out;
    logic        busy;
`ifdef PM1_SHARE_ARB_PERF_EN
    logic [63:0] perf_cnt;
`endif

    // SETTLE=3 instance
    logic [3:0]  req_valid3;
    logic [63:0] req_data3;
    logic [3:0]  req_ready3;
    logic        rsp_valid3;
    logic        rsp_ready3;
    logic [1:0]  rsp_id3;
    logic [12:0] rsp_data3;
    logic [15:0] pm_in3;
    logic [12:0] pm_out3;
    logic        busy3;
`ifdef PM1_SHARE_ARB_PERF_EN
    logic [63:0] perf_cnt3;
`endif

    // Stand-in for pm1: an arbitrary fixed decode with f(0) = 13'h0FB0.
    function automatic logic [12:0] pm1_model(input logic [15:0] x);
        return x[12:0] ^ {x[15:13], 10'h000} ^ 13'h0FB0;
    endfunction

    assign pm_out = pm1_model(pm_in);

    pm1_share_arb #(.NREQ(4), .SETTLE(1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .pm_in     (pm_in),
        .pm_out    (pm_out),
`ifdef PM1_SHARE_ARB_PERF_EN
        .perf_cnt  (perf_cnt),
`endif
        .busy      (busy)
    );

    pm1_share_arb #(.NREQ(4), .SETTLE(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid3),
        .req_data  (req_data3),
        .req_ready (req_ready3),
        .rsp_valid (rsp_valid3),
        .rsp_ready (rsp_ready3),
        .rsp_id    (rsp_id3),
        .rsp_data  (rsp_data3),
        .pm_in     (pm_in3),
        .pm_out    (pm_out3),
`ifdef PM1_SHARE_ARB_PERF_EN
        .perf_cnt  (perf_cnt3),
`endif
        .busy      (busy3)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [63:0] data;
        int unsigned exp_id;
        logic [15:0] exp_pm_in;
    } vec_t;

    vec_t tbl[8];
    int   g_id[6];
    int   g_cyc[6];
    int   ng;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        // Pointer starts at 0 after reset; expected ids follow the rotation by hand.
        tbl[0] = '{4'b0100, {16'hFFFF, 16'h0000, 16'h5555, 16'hAAAA}, 2, 16'h0000};
        tbl[1] = '{4'b0011, {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0}, 0, 16'hDEF0};
        tbl[2] = '{4'b0011, {16'h1111, 16'h2222, 16'h3333, 16'h4444}, 1, 16'h3333};
        tbl[3] = '{4'b1001, {16'h8001, 16'h0000, 16'h0000, 16'h0FF0}, 3, 16'h8001};
        tbl[4] = '{4'b1000, {16'hE00E, 16'h7777, 16'h7777, 16'h7777}, 3, 16'hE00E};
        tbl[5] = '{4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'hA5A5}, 0, 16'hA5A5};
        tbl[6] = '{4'b1111, {16'h4D4D, 16'h3C3C, 16'h2B2B, 16'h1A1A}, 1, 16'h2B2B};
        tbl[7] = '{4'b0001, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0F0F}, 0, 16'h0F0F};

        rst_n      = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        rsp_ready  = 1'b1;
        req_valid3 = '0;
        req_data3  = '0;
        rsp_ready3 = 1'b1;
        pm_out3    = 13'h0111;

        // Reset and idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("idle_outputs[%0d]", i),
                {req_ready, rsp_valid, rsp_id, rsp_data, pm_in, busy}, '0);
        end
`ifdef PM1_SHARE_ARB_PERF_EN
        chk("perf_after_reset", perf_cnt, '0);
`endif

        // Table of single transactions with rsp_ready high
        for (int v = 0; v < 8; v++) begin
            req_valid = tbl[v].valid;
            req_data  = tbl[v].data;
            #1;
            chk($sformatf("tbl%0d_req_ready", v), req_ready, 64'(4'b0001 << tbl[v].exp_id));
            @(negedge clk);
            req_valid = '0;
            #1;
            chk($sformatf("tbl%0d_pm_in", v), pm_in, tbl[v].exp_pm_in);
            chk($sformatf("tbl%0d_settle", v), {busy, rsp_valid, req_ready}, 6'b100000);
            @(negedge clk);
            chk($sformatf("tbl%0d_rsp_valid", v), rsp_valid, 1'b1);
            chk($sformatf("tbl%0d_rsp_id", v), rsp_id, tbl[v].exp_id);
            chk($sformatf("tbl%0d_rsp_data", v), rsp_data, pm1_model(tbl[v].exp_pm_in));
            @(negedge clk);
            chk($sformatf("tbl%0d_back_idle", v), {busy, rsp_valid}, 2'b00);
        end
`ifdef PM1_SHARE_ARB_PERF_EN
        chk("perf_after_table", perf_cnt, {16'd2, 16'd1, 16'd2, 16'd3});
`endif

        // Reset while in SETTLE_S drops the transaction
        req_valid = 4'b0100;
        req_data  = {16'h0000, 16'h4321, 16'h0000, 16'h0000};
        @(negedge clk);
        chk("midrst_in_settle", {busy, pm_in}, {1'b1, 16'h4321});
        rst_n     = 1'b0;
        req_valid = '0;
        @(negedge clk);
        chk("midrst_outputs",
            {req_ready, rsp_valid, rsp_id, rsp_data, pm_in, busy}, '0);
`ifdef PM1_SHARE_ARB_PERF_EN
        chk("midrst_perf", perf_cnt, '0);
`endif
        @(negedge clk);
        chk("midrst_no_rsp", rsp_valid, 1'b0);

        // Round robin from a cleared pointer, all requesters valid
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        req_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        ng = 0;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            #1;
            if (req_ready != 4'b0000) begin
                for (int k = 0; k < 4; k++) if (req_ready[k]) g_id[ng] = k;
                g_cyc[ng] = c;
                ng++;
            end
            @(negedge clk);
        end
        req_valid = '0;
        chk("rr_grant_count", ng, 6);
        for (int i = 0; i < ng; i++) begin
            chk($sformatf("rr_id[%0d]", i), g_id[i], i % 4);
            if (i > 0) chk($sformatf("rr_gap[%0d]", i), g_cyc[i] - g_cyc[i-1], 3);
        end
        for (int i = 0; i < 10 && busy; i++) @(negedge clk);
        chk("rr_drain", busy, 1'b0);

        // Backpressure: pointer is 2, so requester 3 wins before requester 1
        rsp_ready = 1'b0;
        req_valid = 4'b1010;
        req_data  = {16'h3C3C, 16'h0000, 16'h5A5A, 16'h0000};
        #1;
        chk("bp_first_grant", req_ready, 4'b1000);
        @(negedge clk);
        @(negedge clk);
        chk("bp_rsp_valid", rsp_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold[%0d]", i), {rsp_valid, rsp_id, rsp_data, req_ready},
                {1'b1, 2'd3, pm1_model(16'h3C3C), 4'b0000});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_after_hs", {rsp_valid, busy, req_ready}, {1'b0, 1'b0, 4'b0010});
        req_valid = '0;
        @(negedge clk);

        // SETTLE=3: capture takes the pm_out value of the third cycle after the grant
        req_valid3 = 4'b0001;
        req_data3  = {48'h0, 16'h0007};
        #1;
        chk("s3_grant", req_ready3, 4'b0001);
        @(negedge clk);
        req_valid3 = '0;
        pm_out3    = 13'h0AAA;
        chk("s3_pm_in", pm_in3, 16'h0007);
        @(negedge clk);
        pm_out3 = 13'h0BBB;
        chk("s3_wait1", rsp_valid3, 1'b0);
        @(negedge clk);
        pm_out3 = 13'h1C3C;
        chk("s3_wait2", rsp_valid3, 1'b0);
        @(negedge clk);
        pm_out3 = 13'h0DDD;
        chk("s3_rsp", {rsp_valid3, rsp_id3, rsp_data3}, {1'b1, 2'd0, 13'h1C3C});
        @(negedge clk);
        chk("s3_idle", {rsp_valid3, busy3}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
